branch_predictor: RTL
=====================

# branch_predictor

Tournament direction predictor for the IF stage, paired with the stall/control unit that resolves branches in ID. It looks up a local (per-PC history) and a global (gshare) 2-bit counter prediction for the fetch PC and drives `if_br_pr`. It carries that lookup's indices and sub-predictions into an internal IF→ID register so that ID-stage resolution updates exactly the entries that produced the prediction. It owns the BHT, GHR, both PHTs and the chooser table, and applies the update strobes issued by the control unit.

## Interface
- `BHT_IDX_BITS`, 5: local history table index width, taken from PC[BHT_IDX_BITS+1:2].
- `LHIST_BITS`, 6: local history length; the local PHT has 2^LHIST_BITS entries.
- `GHR_BITS`, 6: global history length; the global PHT has 2^GHR_BITS entries.
- `CHOOSER_IDX_BITS`, 6: chooser table index width, taken from PC[CHOOSER_IDX_BITS+1:2].
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_pc` in 32: PC of the instruction being fetched.
- `if_id_reg_load` in 1: advance the internal IF→ID register. Same signal as the pipeline register load.
- `if_id_reg_flush` in 1: invalidate the internal IF→ID register.
- `id_ex_in_br_en` in 1: resolved direction of the branch in ID.
- `ghr_load`, `bht_load` in 1 each: shift the outcome into the GHR / BHT entry.
- `increment_pht`, `decrement_pht` in 1 each: train both direction PHTs.
- `increment_tournament_pht`, `decrement_tournament_pht` in 1 each: train the chooser.
- `if_br_pr` out 1: final prediction for `if_pc`.
- `id_local_pr`, `id_global_pr`, `id_br_pr` out 1 each: the IF-time local, global and final predictions of the instruction now in ID.

## Operation
- Counters are 2-bit saturating. A counter predicts taken when its value is ≥2.
- Lookup (combinational from `if_pc` and the current state):
  - `lidx = BHT[if_pc[BHT_IDX_BITS+1:2]]`; local prediction = `LPHT[lidx]`.
  - `gidx = GHR ^ if_pc[GHR_BITS+1:2]`; global prediction = `GPHT[gidx]`.
  - `cidx = if_pc[CHOOSER_IDX_BITS+1:2]`.
  - `if_br_pr` = global prediction if `CHOOSER[cidx] ≥ 2`, else local prediction. Low chooser values favour local.
- IF→ID register contents: valid, bht index, lidx, gidx, cidx, local_pr, global_pr, final_pr.
  - Flush: clears every field to 0. Flush wins over load when both are asserted.
  - Load without flush: captures the lookup for `if_pc` and sets valid=1.
  - Neither asserted: holds.
- Updates are applied only when the register's valid=1, using the captured indices, never the current `if_pc`.
  - `increment_pht`: LPHT[lidx] and GPHT[gidx] each +1, saturating at 3.
  - `decrement_pht`: the same two entries each −1, saturating at 0.
  - `increment_tournament_pht` / `decrement_tournament_pht`: CHOOSER[cidx] ±1, saturating.
  - `bht_load`: BHT[bht index] ← {entry[LHIST_BITS-2:0], `id_ex_in_br_en`}.
  - `ghr_load`: GHR ← {GHR[GHR_BITS-2:0], `id_ex_in_br_en`}.
- Increment and decrement of the same table asserted together: that table is left unchanged. This combination is not legal, but the behaviour is defined.
- Outputs `id_local_pr`, `id_global_pr`, `id_br_pr` come directly from the register fields and are 0 when valid=0.

## Timing
- Reset state (asynchronous):
  - LPHT, GPHT and CHOOSER entries all 2'b01.
  - BHT and GHR all zero.
  - IF→ID register cleared.
  - Resulting outputs: `if_br_pr`=0 for every PC; all `id_*` outputs 0.
- `if_br_pr` has zero latency: combinational from `if_pc`.
- Updates become visible one cycle later. A lookup in the same cycle as an update to the same entry reads the old value; there is no bypass.
- GHR and BHT are updated non-speculatively, only at ID resolution. An IF lookup in the cycle of `ghr_load` uses the pre-shift GHR.
- Stall (`if_id_reg_load`=0): the register and its outputs hold. Strobes from the control unit are already gated by load.
- Reset asserted mid-operation restores the reset state immediately. The first edge after deassertion behaves as a normal cycle.

## Structure
- Shared `rv32i_types` package gains:
  - `sat2_t` (2-bit counter type);
  - `bp_id_entry_t`, the struct for the IF→ID register contents;
  - localparams `SAT2_RESET`=2'b01 and `SAT2_TAKEN_MIN`=2'd2.
- One sub-module, `sat_counter_table`: parameterised by depth, with one combinational read port, one indexed inc/dec write port, and a reset value. It is instantiated three times: LPHT, GPHT and CHOOSER. BHT and GHR stay inline.

## Test plan
- Reset, then `if_pc`=0x60 → `if_br_pr`=0 and all `id_*` outputs=0. Every PHT and chooser read returns 01.
- Same PC 0x40, valid, `increment_pht` + `bht_load` + `ghr_load` with br_en=1, repeated four times → local PHT saturates at 3. After the history settles, `if_br_pr`=1 for 0x40.
- Chooser entry at 0x40 driven to 3 via `increment_tournament_pht`, GPHT[gidx]=0, LPHT=3 → `if_br_pr`=0 (global selected).
- Load and flush asserted together, then `increment_pht` → no table changes; `id_br_pr`=0.
- `if_id_reg_load`=0 for 3 cycles while `if_pc` changes → `id_*` outputs hold their captured values.
- Decrement at counter 0 → stays 0; increment and decrement asserted together at value 2 → stays 2; reset asserted mid-training → all tables return to reset values.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared RV32I pipeline types, extended with the branch predictor's counter
// type and the IF->ID prediction record.
package rv32i_types;

    typedef logic [1:0] sat2_t;

    localparam sat2_t SAT2_RESET     = 2'b01;
    localparam sat2_t SAT2_TAKEN_MIN = 2'd2;

    // Default predictor geometry; the IF->ID record is sized from these.
    localparam int BP_BHT_IDX_BITS     = 5;
    localparam int BP_LHIST_BITS       = 6;
    localparam int BP_GHR_BITS         = 6;
    localparam int BP_CHOOSER_IDX_BITS = 6;

    typedef struct packed {
        logic                           valid;
        logic [BP_BHT_IDX_BITS-1:0]     bht_idx;
        logic [BP_LHIST_BITS-1:0]       lidx;
        logic [BP_GHR_BITS-1:0]         gidx;
        logic [BP_CHOOSER_IDX_BITS-1:0] cidx;
        logic                           local_pr;
        logic                           global_pr;
        logic                           final_pr;
    } bp_id_entry_t;

    function automatic logic sat2_taken(input sat2_t cnt);
        return cnt >= SAT2_TAKEN_MIN;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter_table.sv
// Table of 2-bit saturating counters: one combinational read port and one
// indexed increment/decrement port.
module sat_counter_table
    import rv32i_types::*;
#(
    parameter int    DEPTH     = 64,
    parameter sat2_t RESET_VAL = SAT2_RESET,
    localparam int   IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output sat2_t               rd_val,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                inc,
    input  logic                dec
);

    sat2_t cnt_q [DEPTH];
    sat2_t cnt_d [DEPTH];

    assign rd_val = cnt_q[rd_idx];

    // Simultaneous inc and dec cancel out and leave the entry unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && cnt_q[wr_idx] != 2'd3) begin
            cnt_d[wr_idx] = cnt_q[wr_idx] + 2'd1;
        end else if (dec && !inc && cnt_q[wr_idx] != 2'd0) begin
            cnt_d[wr_idx] = cnt_q[wr_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= RESET_VAL;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Tournament (local/gshare) direction predictor for IF, with an internal
// IF->ID record so ID-stage resolution trains exactly the entries it used.
module branch_predictor
    import rv32i_types::*;
#(
    parameter int BHT_IDX_BITS     = BP_BHT_IDX_BITS,
    parameter int LHIST_BITS       = BP_LHIST_BITS,
    parameter int GHR_BITS         = BP_GHR_BITS,
    parameter int CHOOSER_IDX_BITS = BP_CHOOSER_IDX_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic        if_id_reg_load,
    input  logic        if_id_reg_flush,
    input  logic        id_ex_in_br_en,
    input  logic        ghr_load,
    input  logic        bht_load,
    input  logic        increment_pht,
    input  logic        decrement_pht,
    input  logic        increment_tournament_pht,
    input  logic        decrement_tournament_pht,
    output logic        if_br_pr,
    output logic        id_local_pr,
    output logic        id_global_pr,
    output logic        id_br_pr
);

    localparam int BHT_DEPTH = 2 ** BHT_IDX_BITS;
    localparam int PC_HI_A   = (BHT_IDX_BITS > GHR_BITS) ? BHT_IDX_BITS : GHR_BITS;
    localparam int PC_HI     = ((PC_HI_A > CHOOSER_IDX_BITS) ? PC_HI_A : CHOOSER_IDX_BITS) + 1;

    logic [LHIST_BITS-1:0]       bht_q [BHT_DEPTH];
    logic [LHIST_BITS-1:0]       bht_d [BHT_DEPTH];
    logic [GHR_BITS-1:0]         ghr_q, ghr_d;
    bp_id_entry_t                id_q, id_d;

    logic [BHT_IDX_BITS-1:0]     bht_rd;
    logic [LHIST_BITS-1:0]       lidx;
    logic [GHR_BITS-1:0]         gidx;
    logic [CHOOSER_IDX_BITS-1:0] cidx;
    sat2_t                       lpht_rd, gpht_rd, chooser_rd;
    logic                        local_pr, global_pr;
    logic                        pht_inc, pht_dec, tour_inc, tour_dec;
    logic                        unused_pc;

    assign unused_pc = ^{if_pc[31:PC_HI+1], if_pc[1:0]};

    assign bht_rd    = if_pc[BHT_IDX_BITS+1:2];
    assign lidx      = bht_q[bht_rd];
    assign gidx      = ghr_q ^ if_pc[GHR_BITS+1:2];
    assign cidx      = if_pc[CHOOSER_IDX_BITS+1:2];
    assign local_pr  = sat2_taken(lpht_rd);
    assign global_pr = sat2_taken(gpht_rd);
    assign if_br_pr  = sat2_taken(chooser_rd) ? global_pr : local_pr;

    // Training strobes only count when ID holds a real prediction record.
    assign pht_inc  = increment_pht & id_q.valid;
    assign pht_dec  = decrement_pht & id_q.valid;
    assign tour_inc = increment_tournament_pht & id_q.valid;
    assign tour_dec = decrement_tournament_pht & id_q.valid;

    sat_counter_table #(.DEPTH(2 ** LHIST_BITS), .RESET_VAL(SAT2_RESET)) u_lpht (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (lidx),
        .rd_val (lpht_rd),
        .wr_idx (id_q.lidx),
        .inc    (pht_inc),
        .dec    (pht_dec)
    );

    sat_counter_table #(.DEPTH(2 ** GHR_BITS), .RESET_VAL(SAT2_RESET)) u_gpht (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (gidx),
        .rd_val (gpht_rd),
        .wr_idx (id_q.gidx),
        .inc    (pht_inc),
        .dec    (pht_dec)
    );

    sat_counter_table #(.DEPTH(2 ** CHOOSER_IDX_BITS), .RESET_VAL(SAT2_RESET)) u_chooser (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_idx (cidx),
        .rd_val (chooser_rd),
        .wr_idx (id_q.cidx),
        .inc    (tour_inc),
        .dec    (tour_dec)
    );

    // Histories advance only on resolved outcomes; lookups see pre-shift values.
    always_comb begin
        bht_d = bht_q;
        ghr_d = ghr_q;
        if (id_q.valid && bht_load) begin
            bht_d[id_q.bht_idx] = {bht_q[id_q.bht_idx][LHIST_BITS-2:0], id_ex_in_br_en};
        end
        if (id_q.valid && ghr_load) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], id_ex_in_br_en};
        end
    end

    always_comb begin
        id_d = id_q;
        if (if_id_reg_flush) begin
            id_d = '0;
        end else if (if_id_reg_load) begin
            id_d.valid     = 1'b1;
            id_d.bht_idx   = bht_rd;
            id_d.lidx      = lidx;
            id_d.gidx      = gidx;
            id_d.cidx      = cidx;
            id_d.local_pr  = local_pr;
            id_d.global_pr = global_pr;
            id_d.final_pr  = if_br_pr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= '0;
            end
            ghr_q <= '0;
            id_q  <= '0;
        end else begin
            bht_q <= bht_d;
            ghr_q <= ghr_d;
            id_q  <= id_d;
        end
    end

    assign id_local_pr  = id_q.valid & id_q.local_pr;
    assign id_global_pr = id_q.valid & id_q.global_pr;
    assign id_br_pr     = id_q.valid & id_q.final_pr;

endmodule
